// File: rtl/mi32_cmd_player_if.sv
// Bus bundle for mi32_cmd_player: command input, read-response output and MI32 master port.
// The master modport is the player itself; slave is the surrounding environment.
interface mi32_cmd_player_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_be;

    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;

    logic [31:0] mi_dwr;
    logic [31:0] mi_addr;
    logic [3:0]  mi_be;
    logic        mi_rd;
    logic        mi_wr;
    logic        mi_ardy;
    logic [31:0] mi_drd;
    logic        mi_drdy;

    modport master (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_data, cmd_be,
        output cmd_ready,
        output rsp_data, rsp_valid,
        input  rsp_ready,
        output mi_dwr, mi_addr, mi_be, mi_rd, mi_wr,
        input  mi_ardy, mi_drd, mi_drdy
    );

    modport slave (
        output cmd_valid, cmd_rd, cmd_addr, cmd_data, cmd_be,
        input  cmd_ready,
        input  rsp_data, rsp_valid,
        output rsp_ready,
        input  mi_dwr, mi_addr, mi_be, mi_rd, mi_wr,
        output mi_ardy, mi_drd, mi_drdy
    );
endinterface

// File: rtl/mi32_cmd_player.sv
// Plays read/write commands onto an MI32 master port through a one-entry request register,
// buffering read data in a credit-guarded first-word-fall-through FIFO.
module mi32_cmd_player #(
    parameter  int RSP_FIFO_DEPTH = 16,
    localparam int AW = $clog2(RSP_FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    mi32_cmd_player_if.master bus,
    output logic [CW-1:0] outstanding,
    output logic          err
);

    logic          req_vld;
    logic          req_rd;
    logic [31:0]   req_addr;
    logic [31:0]   req_data;
    logic [3:0]    req_be;

    logic [CW-1:0] credit;
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [31:0]   mem [RSP_FIFO_DEPTH];

    logic          accept;
    logic          rd_acc;
    logic          mi_done;
    logic          mi_rd_done;
    logic          drdy_ok;
    logic          pop;

    // A read is only accepted when a FIFO slot is already reserved for its data,
    // so the response FIFO can never overflow.
    assign bus.cmd_ready = !reset && (!req_vld || bus.mi_ardy) && (!bus.cmd_rd || credit != '0);

    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign rd_acc     = accept && bus.cmd_rd;
    assign mi_done    = req_vld && bus.mi_ardy;
    assign mi_rd_done = mi_done && req_rd;
    assign drdy_ok    = bus.mi_drdy && (outstanding != '0);
    assign pop        = bus.rsp_valid && bus.rsp_ready;

    assign bus.mi_rd   = req_vld && req_rd;
    assign bus.mi_wr   = req_vld && !req_rd;
    assign bus.mi_addr = req_addr;
    assign bus.mi_dwr  = req_data;
    assign bus.mi_be   = req_be;

    assign bus.rsp_valid = (wr_ptr != rd_ptr);
    assign bus.rsp_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            req_vld  <= 1'b0;
            req_rd   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            req_be   <= '0;
        end else if (accept) begin
            req_vld  <= 1'b1;
            req_rd   <= bus.cmd_rd;
            req_addr <= bus.cmd_addr;
            req_data <= bus.cmd_data;
            req_be   <= bus.cmd_be;
        end else if (mi_done) begin
            req_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit <= CW'(RSP_FIFO_DEPTH);
        end else begin
            case ({rd_acc, pop})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   credit <= credit + CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    // Responses arriving with nothing outstanding are dropped and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            case ({mi_rd_done, drdy_ok})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (bus.mi_drdy && outstanding == '0)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (drdy_ok) wr_ptr <= wr_ptr + CW'(1);
            if (pop)     rd_ptr <= rd_ptr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (drdy_ok)
            mem[wr_ptr[AW-1:0]] <= bus.mi_drd;
    end

endmodule

// File: doc/mi32_cmd_player.md
MI32_CMD_PLAYER -- requirements
Module: mi32_cmd_player

Interface
REQ-001 Parameter RSP_FIFO_DEPTH, default 16, read-response buffer depth in words; power of two, >= 2.
REQ-002 CLK  in  1  single clock; all logic rising-edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 CMD_VALID  in  1  command present.
REQ-005 CMD_READY  out  1  command accepted when CMD_VALID=1 and CMD_READY=1 in the same cycle.
REQ-006 CMD_RD  in  1  1=read, 0=write.
REQ-007 CMD_ADDR  in  32  target address.
REQ-008 CMD_DATA  in  32  write data (ignored for reads).
REQ-009 CMD_BE  in  4  byte enables.
REQ-010 RSP_DATA  out  32  read data at FIFO head.
REQ-011 RSP_VALID  out  1  response FIFO not empty.
REQ-012 RSP_READY  in  1  pop when RSP_VALID=1 and RSP_READY=1.
REQ-013 MI_DWR, MI_ADDR, MI_BE  out  32/32/4  MI32 master request fields.
REQ-014 MI_RD, MI_WR  out  1/1  MI32 master request strobes.
REQ-015 MI_ARDY  in  1  slave accepts request.
REQ-016 MI_DRD  in  32  slave read data.
REQ-017 MI_DRDY  in  1  read data valid; no backpressure.
REQ-018 OUTSTANDING  out  log2(RSP_FIFO_DEPTH)+1  reads issued on MI, DRDY not yet received.
REQ-019 ERR  out  1  sticky: MI_DRDY=1 with OUTSTANDING=0.

Function
REQ-020 One-entry request register (valid, rd, addr, data, be); MI_RD=valid&rd, MI_WR=valid&!rd; MI_ADDR/DWR/BE driven from register, stable while valid.
REQ-021 MI request completes in the cycle valid=1 and MI_ARDY=1; register clears unless refilled that cycle.
REQ-022 CMD_READY = (!valid | MI_ARDY) & (!CMD_RD | credit>0); combinational; CMD_READY may depend on CMD_RD.
REQ-023 Accepted command loads register next edge; back-to-back: accept and MI completion in same cycle gives one request per cycle.
REQ-024 credit counter, range 0..RSP_FIFO_DEPTH, reset RSP_FIFO_DEPTH: -1 on read command acceptance, +1 on RSP pop; both same cycle -> unchanged.
REQ-025 Invariant: FIFO occupancy + OUTSTANDING + (pending read in register) + credit = RSP_FIFO_DEPTH; FIFO cannot overflow.
REQ-026 OUTSTANDING: +1 on completed MI read (MI_RD&MI_ARDY), -1 on MI_DRDY; simultaneous -> unchanged.
REQ-027 MI_DRDY with OUTSTANDING=0: data dropped, not written to FIFO, ERR set, OUTSTANDING stays 0.
REQ-028 MI_DRDY with OUTSTANDING>0: MI_DRD written to FIFO; in-order responses.
REQ-029 FIFO first-word-fall-through: data written at edge N visible on RSP_DATA with RSP_VALID=1 after edge N (1-cycle DRDY-to-RSP_VALID latency).
REQ-030 Simultaneous FIFO write and pop allowed at any occupancy including full and one-entry.
REQ-031 Write commands never consume credit; writes are not blocked by a full response FIFO.
REQ-032 Pointers wrap modulo RSP_FIFO_DEPTH; full/empty distinguished by extra pointer bit.

Reset
REQ-033 While RESET=1: request register invalid, MI_RD=MI_WR=0, CMD_READY=0, RSP_VALID=0, FIFO empty, OUTSTANDING=0, credit=RSP_FIFO_DEPTH, ERR=0; MI_ADDR/DWR/BE=0.
REQ-034 Reset mid-operation discards pending request, FIFO content and outstanding count; late DRDY after reset sets ERR.
REQ-035 CMD_READY may assert the cycle after RESET deasserts.

Verification
REQ-036 Write 0xDEADBEEF to 0x10, BE=0xF, MI_ARDY=1 -> MI_WR=1, MI_ADDR=0x10, MI_DWR=0xDEADBEEF one cycle after accept, single cycle; RSP_VALID stays 0.
REQ-037 MI_ARDY held 0 for 5 cycles with request pending -> MI_RD/WR and fields stable, CMD_READY=0, no second command lost.
REQ-038 DEPTH=16, RSP_READY=0, 20 reads, DRDY 2 cycles after each accept -> exactly 16 issued, CMD_READY=0 for reads, writes still accepted; pop one -> one more read issues.
REQ-039 Reads to 0x0..0x3C, DRDY returns addr+1 -> RSP_DATA sequence 0x1,0x5,...,0x3D in order, OUTSTANDING returns to 0.
REQ-040 MI_DRDY=1 after reset with no read -> ERR=1 held until RESET, RSP_VALID=0.
REQ-041 RESET asserted with 3 outstanding reads and 2 FIFO entries -> next cycle RSP_VALID=0, OUTSTANDING=0, credit restored, MI_RD=0.
